// File: rtl/mem_access_stage.sv
// MEM stage: runs loads/stores on a req/ack data bus, stalls upstream
// while busy, and holds the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  WBreg,
  input  logic [2:0]  Mreg,
  input  logic [31:0] ALUreg,
  input  logic [31:0] WriteDataOut,
  input  logic [4:0]  RegRDreg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [1:0]  WBout,
  output logic [31:0] ReadData,
  output logic [31:0] ALUPass,
  output logic [4:0]  RegRDout,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  wb_q, wb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        err_q, err_d;
  logic        errf_q, errf_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [7:0]  cnt_q, cnt_d;

  logic acc, illegal, misal, acc_ok, tmo;

  assign acc     = Mreg[1] ^ Mreg[0];
  assign illegal = Mreg[1] & Mreg[0];
  assign misal   = acc && (ALUreg[1:0] != 2'b00);
  assign acc_ok  = acc && !misal;
  assign tmo     = (cnt_q == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acc_ok) state_d = BUSY;
      BUSY:    if (mem_ack || tmo) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wb_d    = wb_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    err_d   = 1'b0;
    errf_d  = errf_q;
    rbuf_d  = rbuf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (acc_ok) begin
          stall   = 1'b1;
          wb_d    = 2'b00;
          req_d   = 1'b1;
          we_d    = Mreg[0];
          addr_d  = ALUreg;
          wdata_d = WriteDataOut;
          cnt_d   = 8'd0;
        end else if (illegal || misal) begin
          wb_d    = 2'b00;
          rdata_d = 32'd0;
          alu_d   = ALUreg;
          rd_d    = RegRDreg;
          err_d   = 1'b1;
        end else begin
          wb_d    = WBreg;
          rdata_d = 32'd0;
          alu_d   = ALUreg;
          rd_d    = RegRDreg;
        end
      end
      BUSY: begin
        stall = 1'b1;
        wb_d  = 2'b00;
        if (mem_ack) begin
          rbuf_d = we_q ? 32'd0 : mem_rdata;
          req_d  = 1'b0;
        end else if (tmo) begin
          rbuf_d = 32'd0;
          req_d  = 1'b0;
          errf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        // EX/MEM still holds the finished access; never re-issue it
        wb_d    = errf_q ? 2'b00 : WBreg;
        rdata_d = rbuf_q;
        alu_d   = ALUreg;
        rd_d    = RegRDreg;
        err_d   = errf_q;
        errf_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wb_q    <= 2'b00;
      rdata_q <= 32'd0;
      alu_q   <= 32'd0;
      rd_q    <= 5'd0;
      err_q   <= 1'b0;
      errf_q  <= 1'b0;
      rbuf_q  <= 32'd0;
      cnt_q   <= 8'd0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      errf_q  <= errf_d;
      rbuf_q  <= rbuf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign WBout     = wb_q;
  assign ReadData  = rdata_q;
  assign ALUPass   = alu_q;
  assign RegRDout  = rd_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT=4.
// Inputs change #1 after posedge; outputs sampled at negedge or #1 after posedge.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  WBreg;
  logic [2:0]  Mreg;
  logic [31:0] ALUreg;
  logic [31:0] WriteDataOut;
  logic [4:0]  RegRDreg;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [1:0]  WBout;
  logic [31:0] ReadData;
  logic [31:0] ALUPass;
  logic [4:0]  RegRDout;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clock(clock),
    .reset(reset),
    .WBreg(WBreg),
    .Mreg(Mreg),
    .ALUreg(ALUreg),
    .WriteDataOut(WriteDataOut),
    .RegRDreg(RegRDreg),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .stall(stall),
    .WBout(WBout),
    .ReadData(ReadData),
    .ALUPass(ALUPass),
    .RegRDout(RegRDout),
    .mem_err(mem_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic nop();
    Mreg     = 3'b000;
    WBreg    = 2'b00;
    ALUreg   = 32'd0;
    RegRDreg = 5'd0;
  endtask

  // Present one instruction; ack on BUSY cycle ack_at (0 = never).
  // Returns after the edge that ends the last stalled/unstalled cycle.
  task automatic run_op(input logic [2:0] m, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [1:0] wb,
                        input logic [4:0] rd, input int ack_at,
                        input logic [31:0] rdat,
                        output int stalls, output int reqs);
    int bidx;
    logic st;
    bit done;
    stalls = 0;
    reqs   = 0;
    bidx   = 0;
    done   = 0;
    Mreg = m; ALUreg = addr; WriteDataOut = wd;
    WBreg = wb; RegRDreg = rd;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clock);
      st = stall;
      if (st) stalls++;
      if (mem_req) begin
        reqs++;
        bidx++;
        mem_ack   = (bidx == ack_at);
        mem_rdata = rdat;
      end
      @(posedge clock);
      #1;
      mem_ack = 1'b0;
      if (!st) done = 1;
    end
    if (!done) check("op_bound", 32'd0, 32'd1);
    nop();
  endtask

  int s, r;

  initial begin
    reset = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    WriteDataOut = 32'd0;
    nop();
    step();
    step();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_wb", {30'd0, WBout}, 32'd0);
    check("rst_rdata", ReadData, 32'd0);
    check("rst_alu", ALUPass, 32'd0);
    check("rst_rd", {27'd0, RegRDout}, 32'd0);
    check("rst_err", {31'd0, mem_err}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    reset = 1'b0;

    // ALU pass-through
    run_op(3'b000, 32'h1234, 32'h0, 2'b10, 5'd5, 0, 32'h0, s, r);
    check("alu_stalls", s, 0);
    check("alu_reqs", r, 0);
    check("alu_pass", ALUPass, 32'h1234);
    check("alu_rd", {27'd0, RegRDout}, 32'd5);
    check("alu_wb", {30'd0, WBout}, 32'd2);

    // Load, ack on 3rd BUSY cycle
    run_op(3'b010, 32'h40, 32'h0, 2'b11, 5'd7, 3, 32'hDEADBEEF, s, r);
    check("ld_stalls", s, 4);
    check("ld_reqs", r, 3);
    check("ld_rdata", ReadData, 32'hDEADBEEF);
    check("ld_wb", {30'd0, WBout}, 32'd3);
    check("ld_alu", ALUPass, 32'h40);
    check("ld_rd", {27'd0, RegRDout}, 32'd7);
    check("ld_addr", mem_addr, 32'h40);
    check("ld_we", {31'd0, mem_we}, 32'd0);
    check("ld_err", {31'd0, mem_err}, 32'd0);
    step();
    check("ld_after_wb", {30'd0, WBout}, 32'd0);

    // Store, ack on 1st BUSY cycle; bus read data must be ignored
    run_op(3'b001, 32'h80, 32'hA5A5A5A5, 2'b01, 5'd9, 1, 32'h12345678, s, r);
    check("st_stalls", s, 2);
    check("st_reqs", r, 1);
    check("st_we", {31'd0, mem_we}, 32'd1);
    check("st_wdata", mem_wdata, 32'hA5A5A5A5);
    check("st_addr", mem_addr, 32'h80);
    check("st_rdata", ReadData, 32'd0);
    check("st_wb", {30'd0, WBout}, 32'd1);
    check("st_req_off", {31'd0, mem_req}, 32'd0);

    // Misaligned load
    run_op(3'b010, 32'h42, 32'h0, 2'b11, 5'd3, 1, 32'h0, s, r);
    check("mis_stalls", s, 0);
    check("mis_reqs", r, 0);
    check("mis_wb", {30'd0, WBout}, 32'd0);
    check("mis_err", {31'd0, mem_err}, 32'd1);
    check("mis_alu", ALUPass, 32'h42);
    check("mis_rd", {27'd0, RegRDout}, 32'd3);
    step();
    check("mis_err_pulse", {31'd0, mem_err}, 32'd0);

    // Illegal MemRead+MemWrite
    run_op(3'b011, 32'h44, 32'h0, 2'b11, 5'd4, 1, 32'h0, s, r);
    check("ill_stalls", s, 0);
    check("ill_reqs", r, 0);
    check("ill_wb", {30'd0, WBout}, 32'd0);
    check("ill_err", {31'd0, mem_err}, 32'd1);
    step();
    check("ill_err_pulse", {31'd0, mem_err}, 32'd0);

    // Ack on the last allowed BUSY cycle counts as success
    run_op(3'b010, 32'h100, 32'h0, 2'b10, 5'd11, 4, 32'hCAFEF00D, s, r);
    check("ack4_stalls", s, 5);
    check("ack4_reqs", r, 4);
    check("ack4_rdata", ReadData, 32'hCAFEF00D);
    check("ack4_wb", {30'd0, WBout}, 32'd2);
    check("ack4_err", {31'd0, mem_err}, 32'd0);

    // Timeout, no ack
    run_op(3'b010, 32'h200, 32'h0, 2'b11, 5'd12, 0, 32'h0, s, r);
    check("tmo_stalls", s, 5);
    check("tmo_reqs", r, 4);
    check("tmo_wb", {30'd0, WBout}, 32'd0);
    check("tmo_rdata", ReadData, 32'd0);
    check("tmo_err", {31'd0, mem_err}, 32'd1);
    check("tmo_alu", ALUPass, 32'h200);
    step();
    check("tmo_err_pulse", {31'd0, mem_err}, 32'd0);

    // Reset on 2nd BUSY cycle
    Mreg = 3'b010; ALUreg = 32'h300; WBreg = 2'b11; RegRDreg = 5'd13;
    step();
    check("rb_busy_req", {31'd0, mem_req}, 32'd1);
    step();
    check("rb_busy2_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    nop();
    #1;
    check("rb_req", {31'd0, mem_req}, 32'd0);
    check("rb_stall", {31'd0, stall}, 32'd0);
    check("rb_addr", mem_addr, 32'd0);
    check("rb_alu", ALUPass, 32'd0);
    check("rb_wb", {30'd0, WBout}, 32'd0);
    check("rb_err", {31'd0, mem_err}, 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    step();
    mem_ack = 1'b0;
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    check("late_ack_stall", {31'd0, stall}, 32'd0);
    step();
    check("late_ack_rdata", ReadData, 32'd0);
    check("late_ack_err", {31'd0, mem_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
